eth_rx_buf_ctrl: RTL
====================

ETH_RX_BUF_CTRL -- requirements
Module: eth_rx_buf_ctrl

Interface
REQ-001 SHALL have parameters: AW, default 12, packet RAM byte-address width; DDEPTH, default 4, descriptor FIFO depth (power of 2).
REQ-002 clk50  in  1  50MHz RMII clock, sole clock.
REQ-003 rst  in  1  reset; asynchronous, active-high.
REQ-004 rx_data  in  8  byte from RMII receiver.
REQ-005 rx_valid  in  1  rx_data holds a frame byte.
REQ-006 rx_sop  in  1  one-clock pulse before first byte.
REQ-007 rx_eop  in  1  one-clock pulse after last byte.
REQ-008 rx_crc_ok  in  1  FCS good; valid in rx_eop cycle.
REQ-009 wr_en / wr_addr / wr_data  out  1 / AW / 8  write port to external packet RAM.
REQ-010 pkt_ready  out  1  at least one committed packet queued.
REQ-011 pkt_base / pkt_len  out  AW / 12  RAM address and byte length (FCS included) of oldest packet.
REQ-012 pkt_done  in  1  one-clock pulse; consumer releases oldest packet.
REQ-013 ok_cnt / drop_cnt / err_cnt  out  16 each  committed, resource-dropped, CRC/runt-rejected frame counts.

Function
REQ-014 FSM states: IDLE, RECV, DROP, COMMIT.
REQ-015 IDLE + rx_sop: descriptor FIFO not full -> RECV, tmp_ptr=wr_ptr, len=0; full -> DROP, drop_cnt++.
REQ-016 RECV + rx_valid: byte stored when (tmp_ptr+1) mod 2^AW != rd_ptr and len < ETH_MAX_FRAME; tmp_ptr++, len++.
REQ-017 Store latency: wr_en=1, wr_addr=old tmp_ptr, wr_data=rx_data registered, one clock after rx_valid.
REQ-018 RECV + rx_valid with no space or len = ETH_MAX_FRAME -> DROP, drop_cnt++, no write.
REQ-019 RECV + rx_eop: rx_crc_ok=1 and len >= ETH_MIN_FRAME -> COMMIT; else -> IDLE, err_cnt++, tmp_ptr discarded.
REQ-020 COMMIT (one clock): push {wr_ptr,len}, wr_ptr=tmp_ptr, ok_cnt++, -> IDLE; pkt_ready visible two clocks after rx_eop.
REQ-021 DROP: ignore rx_valid; rx_eop -> IDLE; no further count for that frame.
REQ-022 RECV or DROP + rx_sop (lost eop): abandon current frame uncommitted, drop_cnt++, re-evaluate as IDLE rule REQ-015 same cycle.
REQ-023 rx_valid/rx_eop in IDLE ignored.
REQ-024 pkt_done with pkt_ready=1: rd_ptr=pkt_base+pkt_len mod 2^AW, pop FIFO; pkt_done with pkt_ready=0 ignored.
REQ-025 COMMIT push and pkt_done pop in same clock both SHALL take effect; occupancy unchanged.
REQ-026 All pointer arithmetic modulo 2^AW; packets SHALL wrap across RAM end contiguously.
REQ-027 One RAM byte always left unused; wr_ptr == rd_ptr means empty.
REQ-028 Counters saturate at 16'hFFFF.
REQ-029 pkt_base/pkt_len SHALL be stable while pkt_ready=1 and no pkt_done.

Reset
REQ-030 rst asserted: state=IDLE, wr_ptr=rd_ptr=tmp_ptr=0, len=0, FIFO empty, all outputs 0, counters 0, immediately (async).
REQ-031 rst deasserted mid-frame: frame SHALL NOT be recovered; next rx_sop starts cleanly.

Structure
REQ-032 Package eth_pkg SHALL hold ETH_MIN_FRAME=64, ETH_MAX_FRAME=1522, FSM state enum, descriptor struct {base, len}.
REQ-033 Descriptor queue SHALL be sub-module eth_desc_fifo (synchronous, DDEPTH entries, full/empty flags, simultaneous push/pop).
REQ-034 Packet RAM external; block contains no byte storage.

Verification
REQ-035 100-byte frame, crc_ok=1 -> 100 writes addr 0..99, pkt_base=0, pkt_len=100, ok_cnt=1.
REQ-036 80-byte frame crc_ok=0, then 40-byte frame crc_ok=1 -> no descriptors, err_cnt=2, next frame base reuses 0.
REQ-037 5 good 64-byte frames, no pkt_done -> 4 committed, 5th drop_cnt=1, no writes for it.
REQ-038 AW=8, pre-advance rd_ptr=wr_ptr=250, 64-byte frame -> addrs 250..255,0..57, pkt_len=64; 200-byte frame without pkt_done -> DROP.
REQ-039 pkt_done coincident with COMMIT of 2nd packet -> FIFO count stays 1, pkt_base advances to 2nd packet.
REQ-040 rst asserted mid-frame after 30 bytes -> outputs 0 same clock, no descriptor, following good frame base 0.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet receive buffer controller.
package eth_pkg;

  localparam int ETH_MIN_FRAME = 64;
  localparam int ETH_MAX_FRAME = 1522;
  localparam int ETH_LEN_W     = 12;
  localparam int ETH_BASE_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DROP,
    COMMIT
  } eth_state_t;

  // Descriptor base is sized for the widest supported RAM (AW <= 16).
  typedef struct packed {
    logic [ETH_BASE_W-1:0] base;
    logic [ETH_LEN_W-1:0]  len;
  } eth_desc_t;

  // Saturating add used by the frame statistics counters.
  function automatic logic [15:0] sat_add(input logic [15:0] v, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, v} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/eth_desc_fifo.sv
// Small synchronous FIFO of committed packet descriptors; push and pop may
// happen in the same clock, and a push into a full FIFO is accepted only
// when a pop frees a slot in that same clock.
module eth_desc_fifo
  import eth_pkg::*;
#(
  parameter int DDEPTH = 4
) (
  input  logic      clk50,
  input  logic      rst,
  input  logic      push,
  input  logic      pop,
  input  eth_desc_t din,
  output eth_desc_t dout,
  output logic      full,
  output logic      empty
);

  localparam int IW = $clog2(DDEPTH);

  eth_desc_t     mem [DDEPTH];
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] rd_idx;
  logic [IW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (IW+1)'(DDEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_idx];

  // Descriptor storage; contents are meaningless while empty, so no reset.
  always_ff @(posedge clk50) begin
    if (do_push) mem[wr_idx] <= din;
  end

  // Index and occupancy bookkeeping; indices wrap naturally (power-of-2 depth).
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_idx <= wr_idx + 1'b1;
      if (do_pop)  rd_idx <= rd_idx + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/eth_rx_buf_ctrl.sv
// Receive-side buffer controller: streams RMII frame bytes into an external
// circular packet RAM, commits good frames as descriptors and frees RAM
// space as the consumer releases packets.
module eth_rx_buf_ctrl
  import eth_pkg::*;
#(
  parameter int AW     = 12,
  parameter int DDEPTH = 4
) (
  input  logic                 clk50,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  input  logic                 rx_sop,
  input  logic                 rx_eop,
  input  logic                 rx_crc_ok,
  output logic                 wr_en,
  output logic [AW-1:0]        wr_addr,
  output logic [7:0]           wr_data,
  output logic                 pkt_ready,
  output logic [AW-1:0]        pkt_base,
  output logic [ETH_LEN_W-1:0] pkt_len,
  input  logic                 pkt_done,
  output logic [15:0]          ok_cnt,
  output logic [15:0]          drop_cnt,
  output logic [15:0]          err_cnt
);

  localparam logic [ETH_LEN_W-1:0] LEN_MIN = ETH_LEN_W'(ETH_MIN_FRAME);
  localparam logic [ETH_LEN_W-1:0] LEN_MAX = ETH_LEN_W'(ETH_MAX_FRAME);

  eth_state_t           state;
  eth_state_t           state_nxt;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        tmp_ptr;
  logic [AW-1:0]        tmp_inc;
  logic [ETH_LEN_W-1:0] len;
  logic                 has_space;
  logic                 start_frame;
  logic                 store_byte;
  logic                 commit;
  logic                 inc_err;
  logic [1:0]           drop_inc;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  eth_desc_t            push_desc;
  eth_desc_t            head;

  // One byte is always kept free so that wr_ptr == rd_ptr can only mean empty.
  assign tmp_inc   = tmp_ptr + 1'b1;
  assign has_space = (tmp_inc != rd_ptr);

  assign push_desc = '{base: ETH_BASE_W'(wr_ptr), len: len};
  assign pop       = pkt_done && !fifo_empty;
  assign pkt_ready = !fifo_empty;
  assign pkt_base  = fifo_empty ? '0 : head.base[AW-1:0];
  assign pkt_len   = fifo_empty ? '0 : head.len;

  eth_desc_fifo #(
    .DDEPTH(DDEPTH)
  ) u_desc_fifo (
    .clk50(clk50),
    .rst  (rst),
    .push (commit),
    .pop  (pop),
    .din  (push_desc),
    .dout (head),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // Frame FSM state register.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and per-cycle datapath strobes; a new sop always restarts framing.
  always_comb begin
    state_nxt   = state;
    start_frame = 1'b0;
    store_byte  = 1'b0;
    commit      = 1'b0;
    inc_err     = 1'b0;
    drop_inc    = 2'd0;
    if (rx_sop && state != COMMIT) begin
      if (state != IDLE) drop_inc = 2'd1;
      if (fifo_full) begin
        state_nxt = DROP;
        drop_inc  = drop_inc + 2'd1;
      end else begin
        state_nxt   = RECV;
        start_frame = 1'b1;
      end
    end else begin
      case (state)
        RECV: begin
          if (rx_eop) begin
            if (rx_crc_ok && len >= LEN_MIN) begin
              state_nxt = COMMIT;
            end else begin
              state_nxt = IDLE;
              inc_err   = 1'b1;
            end
          end else if (rx_valid) begin
            if (has_space && len < LEN_MAX) begin
              store_byte = 1'b1;
            end else begin
              state_nxt = DROP;
              drop_inc  = 2'd1;
            end
          end
        end
        DROP: begin
          if (rx_eop) state_nxt = IDLE;
        end
        COMMIT: begin
          commit    = 1'b1;
          state_nxt = IDLE;
        end
        default: state_nxt = state;
      endcase
    end
  end

  // RAM write port, frame pointers and release of consumed packets.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      tmp_ptr <= '0;
      len     <= '0;
    end else begin
      wr_en <= store_byte;
      if (store_byte) begin
        wr_addr <= tmp_ptr;
        wr_data <= rx_data;
        tmp_ptr <= tmp_inc;
        len     <= len + 1'b1;
      end
      if (start_frame) begin
        tmp_ptr <= wr_ptr;
        len     <= '0;
      end
      if (commit) wr_ptr <= tmp_ptr;
      if (pop)    rd_ptr <= AW'(head.base + ETH_BASE_W'(head.len));
    end
  end

  // Saturating frame statistics.
  always_ff @(posedge clk50 or posedge rst) begin
    if (rst) begin
      ok_cnt   <= '0;
      drop_cnt <= '0;
      err_cnt  <= '0;
    end else begin
      if (commit)          ok_cnt   <= sat_add(ok_cnt, 2'd1);
      if (drop_inc != '0)  drop_cnt <= sat_add(drop_cnt, drop_inc);
      if (inc_err)         err_cnt  <= sat_add(err_cnt, 2'd1);
    end
  end

endmodule
